hiera_cla: RTL and testbench

//  16-bit two-level (hierarchical) carry-lookahead adder with carry-in/out.

---
 rtl/hiera_cla_pkg.sv | 10 +
 rtl/hiera_cla_cla4.sv | 35 +++
 rtl/hiera_cla.sv | 63 ++++++
 tb/tb_hiera_cla.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hiera_cla_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hiera_cla_pkg;

  localparam int WIDTH      = 16;
  localparam int GROUP_W    = 4;
  localparam int NUM_GROUPS = WIDTH / GROUP_W;

endpackage

// File: rtl/hiera_cla_cla4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module cla4
  import hiera_cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               pg,
  output logic               gg
);

  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] c;

  // Bit propagate/generate, lookahead carries from the group carry-in, sum bits.
  always_comb begin
    p = a ^ b;
    g = a & b;

    // Every internal carry is a flat sum-of-products of cin, so no ripple path.
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    s  = p ^ c;
    pg = &p;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/hiera_cla.sv
// 16-bit two-level carry-lookahead adder with registered sum and carry-out.
// Latency: 1 cycle from operand sample to sum/c_out; one add per cycle.
// Backpressure: none; a new result is accepted every clock with no handshake.
module hiera_cla
  import hiera_cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_1,
  input  logic [WIDTH-1:0] add_2,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS:0]   grp_c;
  logic [WIDTH-1:0]      sum_comb;

  // First level: four independent 4-bit lookahead groups.
  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
    cla4 u_cla4 (
      .a   (add_1[k*GROUP_W +: GROUP_W]),
      .b   (add_2[k*GROUP_W +: GROUP_W]),
      .cin (grp_c[k]),
      .s   (sum_comb[k*GROUP_W +: GROUP_W]),
      .pg  (grp_p[k]),
      .gg  (grp_g[k])
    );
  end

  // Second level: inter-group carries computed directly from c_in and group P/G.
  always_comb begin
    grp_c[0] = c_in;
    grp_c[1] = grp_g[0]
             | (grp_p[0] & c_in);
    grp_c[2] = grp_g[1]
             | (grp_p[1] & grp_g[0])
             | (grp_p[1] & grp_p[0] & c_in);
    grp_c[3] = grp_g[2]
             | (grp_p[2] & grp_g[1])
             | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & c_in);
    grp_c[4] = grp_g[3]
             | (grp_p[3] & grp_g[2])
             | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c_in);
  end

  // Output register; reset wins over a fresh result on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_comb;
      c_out <= grp_c[NUM_GROUPS];
    end
  end

endmodule

// File: tb/tb_hiera_cla.sv
// Bench for hiera_cla: directed vector table, reset sequences, random stream.
// Latency: expects each result one clock after its operands.
// Backpressure: n/a.
module tb_hiera_cla;

  logic        clk;
  logic        rst;
  logic [15:0] add_1;
  logic [15:0] add_2;
  logic        c_in;
  logic [15:0] sum;
  logic        c_out;

  int checks = 0;
  int errors = 0;

  hiera_cla dut (
    .clk   (clk),
    .rst   (rst),
    .add_1 (add_1),
    .add_2 (add_2),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;   // {c_out, sum}
  } vec_t;

  vec_t tbl[10];

  // 17-bit exact reference: plain integer addition.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    return 17'(a) + 17'(b) + 17'(ci);
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    checks++;
    if ({c_out, sum} !== exp) begin
      errors++;
      $display("FAIL %s: got c_out=%0b sum=%h, expected c_out=%0b sum=%h",
               name, c_out, sum, exp[16], exp[15:0]);
    end
  endtask

  // Apply inputs, clock once, sample 1ns after the edge.
  task automatic step(input logic r, input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
    rst   = r;
    add_1 = a;
    add_2 = b;
    c_in  = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rci;
    logic        rr;
    logic [16:0] rexp;

    tbl[0] = '{"dec_cin1",      16'd432,   16'd765, 1'b1, 17'd1198};
    tbl[1] = '{"dec_cin0",      16'd432,   16'd765, 1'b0, 17'd1197};
    tbl[2] = '{"fffe_plus_1",   16'd65534, 16'd1,   1'b0, {1'b0, 16'hFFFF}};
    tbl[3] = '{"fffe_1_cin",    16'd65534, 16'd1,   1'b1, {1'b1, 16'h0000}};
    tbl[4] = '{"ones_ones_cin", 16'hFFFF,  16'hFFFF, 1'b1, {1'b1, 16'hFFFF}};
    tbl[5] = '{"cross_group",   16'h0FFF,  16'h0001, 1'b0, {1'b0, 16'h1000}};
    tbl[6] = '{"ones_zero_cin", 16'hFFFF,  16'h0000, 1'b1, {1'b1, 16'h0000}};
    tbl[7] = '{"ones_zero",     16'hFFFF,  16'h0000, 1'b0, {1'b0, 16'hFFFF}};
    tbl[8] = '{"msb_overflow",  16'h8000,  16'h8000, 1'b0, {1'b1, 16'h0000}};
    tbl[9] = '{"grp1_carry",    16'h00F0,  16'h0010, 1'b0, {1'b0, 16'h0100}};

    rst = 1'b1; add_1 = 16'h1234; add_2 = 16'h4321; c_in = 1'b1;
    #1;

    // Reset held two cycles with live operands on the bus.
    step(1'b1, 16'hABCD, 16'h1234, 1'b1);
    check("reset_cyc1", 17'd0);
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check("reset_cyc2", 17'd0);

    // Directed vectors, back to back.
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].a, tbl[i].b, tbl[i].ci);
      check(tbl[i].name, tbl[i].exp);
    end

    // Mid-stream reset: clears on that edge, result returns one cycle after release.
    step(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    check("pre_rst", {1'b1, 16'hFFFF});
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0);
    check("mid_rst", 17'd0);
    step(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    check("post_rst_first", {1'b0, 16'h8000});
    step(1'b0, 16'h0000, 16'h0000, 1'b0);
    check("zero_add", 17'd0);

    // Random stream with occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rci  = 1'($urandom);
      rr   = ($urandom_range(0, 19) == 0);
      if (n % 8 == 3) rb = ~ra;  // long propagate chains
      rexp = rr ? 17'd0 : ref_add(ra, rb, rci);
      step(rr, ra, rb, rci);
      check(rr ? "rand_rst" : "rand_add", rexp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
